// File: rtl/conv1d_if.sv
// Bus bundle between the Conv1D compute engine and its control source and SRAM ports.
// The master modport is the engine side; the slave modport is the SRAM/controller side.
interface conv1d_if #(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter int para_deg   = 4
);
  logic                           Start;
  logic [addr_width:0]            Num_Words;
  logic                           Busy;
  logic                           Done;
  logic                           In_Chip_Select;
  logic                           In_En_Read;
  logic [addr_width-1:0]          In_Read_Addr;
  logic [para_deg*data_width-1:0] In_Read_Data;
  logic                           Ker_Chip_Select;
  logic                           Ker_En_Read;
  logic [addr_width-1:0]          Ker_Read_Addr;
  logic [para_deg*data_width-1:0] Ker_Read_Data;
  logic                           Out_Chip_Select;
  logic                           Out_En_Write;
  logic [addr_width-1:0]          Out_Write_Addr;
  logic [para_deg*data_width-1:0] Out_Write_Data;

  modport master (
    input  Start, Num_Words, In_Read_Data, Ker_Read_Data,
    output Busy, Done,
    output In_Chip_Select, In_En_Read, In_Read_Addr,
    output Ker_Chip_Select, Ker_En_Read, Ker_Read_Addr,
    output Out_Chip_Select, Out_En_Write, Out_Write_Addr, Out_Write_Data
  );

  modport slave (
    output Start, Num_Words, In_Read_Data, Ker_Read_Data,
    input  Busy, Done,
    input  In_Chip_Select, In_En_Read, In_Read_Addr,
    input  Ker_Chip_Select, Ker_En_Read, Ker_Read_Addr,
    input  Out_Chip_Select, Out_En_Write, Out_Write_Addr, Out_Write_Data
  );
endinterface

// File: rtl/conv1d_engine.sv
// Conv1D compute stage: streams input words from sram0, convolves with the kernel from sram1
// (tail zero-padded, saturating) and writes one result word per cycle into sram2.
module conv1d_engine #(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter int para_deg   = 4
) (
  input  logic     clk,
  input  logic     rst,
  conv1d_if.master bus
);
  localparam int ram_depth = 1 << addr_width;
  localparam int word_w    = para_deg * data_width;
  localparam int acc_w     = 2 * data_width + $clog2(para_deg);
  localparam int cnt_w     = addr_width + 1;

  typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, DONE} state_t;

  state_t              state_r;
  logic                prime_r;
  logic                busy_r;
  logic                done_r;
  logic                in_en_r;
  logic [addr_width-1:0] in_addr_r;
  logic                ker_en_r;
  logic                out_en_r;
  logic [addr_width-1:0] out_addr_r;
  logic [word_w-1:0]   out_data_r;
  logic [cnt_w-1:0]    n_r;
  logic [cnt_w-1:0]    rd_next_r;
  logic [cnt_w-1:0]    cons_r;
  logic [cnt_w-1:0]    wr_cnt_r;
  logic [word_w-1:0]   ker_r;
  logic [word_w-1:0]   cur_r;

  logic [cnt_w-1:0]    clamp_s;
  logic                rd_go_s;
  logic [word_w-1:0]   nxt_s;

  // P outputs from a 2P-sample window {hi, lo}, each saturated to the element width.
  function automatic logic [word_w-1:0] conv_word(input logic [word_w-1:0] lo,
                                                  input logic [word_w-1:0] hi,
                                                  input logic [word_w-1:0] ker);
    logic [2*word_w-1:0]     win;
    logic [acc_w-1:0]        acc;
    logic [2*data_width-1:0] prod;
    logic [word_w-1:0]       res;
    win = {hi, lo};
    res = '0;
    for (int i = 0; i < para_deg; i++) begin
      acc = '0;
      for (int k = 0; k < para_deg; k++) begin
        prod = win[(i+k)*data_width +: data_width] * ker[k*data_width +: data_width];
        acc  = acc + acc_w'(prod);
      end
      if (acc[acc_w-1:data_width] != '0) begin
        res[i*data_width +: data_width] = {data_width{1'b1}};
      end else begin
        res[i*data_width +: data_width] = acc[data_width-1:0];
      end
    end
    return res;
  endfunction

  // Word-count clamp, read-issue decision and the incoming (or zero-padded) window word.
  always_comb begin
    clamp_s = bus.Num_Words;
    rd_go_s = 1'b0;
    nxt_s   = '0;
    if (bus.Num_Words > cnt_w'(ram_depth)) begin
      clamp_s = cnt_w'(ram_depth);
    end else begin
      clamp_s = bus.Num_Words;
    end
    rd_go_s = (rd_next_r < n_r);
    if (cons_r < n_r) begin
      nxt_s = bus.In_Read_Data;
    end else begin
      nxt_s = '0;
    end
  end

  // Control FSM and datapath; word j+1 arrives on In_Read_Data in the same cycle word j sits in cur_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      prime_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      in_en_r    <= 1'b0;
      in_addr_r  <= '0;
      ker_en_r   <= 1'b0;
      out_en_r   <= 1'b0;
      out_addr_r <= '0;
      out_data_r <= '0;
      n_r        <= '0;
      rd_next_r  <= '0;
      cons_r     <= '0;
      wr_cnt_r   <= '0;
      ker_r      <= '0;
      cur_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r     <= 1'b0;
          in_en_r    <= 1'b0;
          ker_en_r   <= 1'b0;
          out_en_r   <= 1'b0;
          out_data_r <= '0;
          if (bus.Start) begin
            busy_r   <= 1'b1;
            n_r      <= clamp_s;
            wr_cnt_r <= '0;
            cons_r   <= '0;
            prime_r  <= 1'b0;
            if (clamp_s == '0) begin
              state_r <= DONE;
            end else begin
              state_r   <= PRIME;
              in_en_r   <= 1'b1;
              in_addr_r <= '0;
              ker_en_r  <= 1'b1;
              rd_next_r <= cnt_w'(1);
            end
          end
        end
        PRIME: begin
          ker_en_r <= 1'b0;
          in_en_r  <= rd_go_s;
          if (rd_go_s) begin
            in_addr_r <= rd_next_r[addr_width-1:0];
            rd_next_r <= rd_next_r + cnt_w'(1);
          end
          if (!prime_r) begin
            prime_r <= 1'b1;
          end else begin
            ker_r   <= bus.Ker_Read_Data;
            cur_r   <= bus.In_Read_Data;
            cons_r  <= cnt_w'(1);
            state_r <= RUN;
          end
        end
        RUN: begin
          in_en_r <= rd_go_s;
          if (rd_go_s) begin
            in_addr_r <= rd_next_r[addr_width-1:0];
            rd_next_r <= rd_next_r + cnt_w'(1);
          end
          out_en_r   <= 1'b1;
          out_addr_r <= wr_cnt_r[addr_width-1:0];
          out_data_r <= conv_word(cur_r, nxt_s, ker_r);
          cur_r      <= nxt_s;
          cons_r     <= cons_r + cnt_w'(1);
          wr_cnt_r   <= wr_cnt_r + cnt_w'(1);
          if ((wr_cnt_r + cnt_w'(1)) == n_r) begin
            state_r <= FLUSH;
          end
        end
        FLUSH: begin
          in_en_r    <= 1'b0;
          out_en_r   <= 1'b0;
          out_data_r <= '0;
          done_r     <= 1'b1;
          state_r    <= DONE;
        end
        DONE: begin
          if (!done_r) begin
            done_r <= 1'b1;
          end else begin
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy            = busy_r;
  assign bus.Done            = done_r;
  assign bus.In_Chip_Select  = busy_r;
  assign bus.In_En_Read      = in_en_r;
  assign bus.In_Read_Addr    = in_addr_r;
  assign bus.Ker_Chip_Select = busy_r;
  assign bus.Ker_En_Read     = ker_en_r;
  assign bus.Ker_Read_Addr   = '0;
  assign bus.Out_Chip_Select = busy_r;
  assign bus.Out_En_Write    = out_en_r;
  assign bus.Out_Write_Addr  = out_addr_r;
  assign bus.Out_Write_Data  = out_data_r;
endmodule

// File: tb/tb_conv1d_engine.sv
// Directed bench for conv1d_engine: SRAM models, a reference convolution model and a write scoreboard.
module tb_conv1d_engine;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  conv1d_if #(.data_width(8), .addr_width(4), .para_deg(4)) bus ();

  conv1d_engine #(.data_width(8), .addr_width(4), .para_deg(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  logic [31:0] mem2 [16];
  logic [31:0] expq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM read ports (1-cycle latency, data held between reads) and the output write port.
  always @(posedge clk) begin
    if (bus.In_Chip_Select && bus.In_En_Read) bus.In_Read_Data <= mem0[bus.In_Read_Addr];
    if (bus.Ker_Chip_Select && bus.Ker_En_Read) bus.Ker_Read_Data <= mem1[bus.Ker_Read_Addr];
    if (bus.Out_Chip_Select && bus.Out_En_Write) mem2[bus.Out_Write_Addr] <= bus.Out_Write_Data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int n, input int j);
    logic [31:0] r;
    logic [31:0] wd;
    logic [31:0] kw;
    int acc;
    int idx;
    int xi;
    r  = 32'h0;
    kw = mem1[0];
    for (int i = 0; i < 4; i++) begin
      acc = 0;
      for (int k = 0; k < 4; k++) begin
        idx = j * 4 + i + k;
        if (idx < n * 4) begin
          wd = mem0[idx / 4];
          xi = int'(wd[(idx % 4) * 8 +: 8]);
        end else begin
          xi = 0;
        end
        acc += xi * int'(kw[k * 8 +: 8]);
      end
      r[i * 8 +: 8] = (acc > 255) ? 8'd255 : acc[7:0];
    end
    return r;
  endfunction

  task automatic run(input string tag, input int n, input bit poke);
    int eff;
    int dones;
    int done_cyc;
    int writes;
    int first_w;
    int bad_rd;
    logic [31:0] e;
    eff      = (n > 16) ? 16 : n;
    dones    = 0;
    done_cyc = -1;
    writes   = 0;
    first_w  = -1;
    bad_rd   = 0;
    for (int j = 0; j < eff; j++) expq.push_back(model_word(eff, j));
    @(negedge clk);
    bus.Start     = 1'b1;
    bus.Num_Words = 5'(n);
    @(posedge clk);
    #1 bus.Start = 1'b0;
    for (int c = 0; c <= eff + 8; c++) begin
      @(negedge clk);
      if (bus.Done) begin
        dones++;
        done_cyc = c;
      end
      if (bus.Out_En_Write) begin
        if (first_w < 0) first_w = c;
        if (expq.size() == 0) begin
          check({tag, "_extra_write"}, 64'(bus.Out_Write_Addr), 64'hFFFF);
        end else begin
          e = expq.pop_front();
          check({tag, "_addr"}, 64'(bus.Out_Write_Addr), 64'(writes));
          check({tag, "_data"}, 64'(bus.Out_Write_Data), 64'(e));
        end
        writes++;
      end else if (bus.Out_Write_Data !== 32'h0) begin
        check({tag, "_idle_data"}, 64'(bus.Out_Write_Data), 64'h0);
      end
      if (bus.In_En_Read && (int'(bus.In_Read_Addr) >= eff)) bad_rd++;
      if (bus.Ker_En_Read && (eff == 0)) bad_rd++;
      if (poke && (c == 4)) begin
        bus.Start     = 1'b1;
        bus.Num_Words = 5'd2;
      end else begin
        bus.Start = 1'b0;
      end
    end
    check({tag, "_dones"}, 64'(dones), 64'd1);
    check({tag, "_done_cyc"}, 64'(done_cyc), (eff == 0) ? 64'd1 : 64'(eff + 3));
    check({tag, "_writes"}, 64'(writes), 64'(eff));
    if (eff > 0) check({tag, "_first_w"}, 64'(first_w), 64'd3);
    check({tag, "_bad_reads"}, 64'(bad_rd), 64'd0);
    check({tag, "_queue"}, 64'(expq.size()), 64'd0);
    expq.delete();
  endtask

  initial begin
    int cnt;
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.Start     = 1'b0;
    bus.Num_Words = 5'd0;
    bus.In_Read_Data  = 32'h0;
    bus.Ker_Read_Data = 32'h0;
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 4; k++) mem0[j][k * 8 +: 8] = 8'(4 * j + k + 1);
      mem1[j] = 32'h0;
      mem2[j] = 32'h0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_wen", 64'(bus.Out_En_Write), 64'd0);
    check("rst_ren", 64'(bus.In_En_Read), 64'd0);
    check("rst_wdata", 64'(bus.Out_Write_Data), 64'd0);
    rst = 1'b0;

    // Identity kernel reproduces the input words.
    mem1[0] = {8'd0, 8'd0, 8'd0, 8'd1};
    run("ident", 4, 1'b0);
    for (int j = 0; j < 4; j++) check("ident_mem", 64'(mem2[j]), 64'(mem0[j]));

    // Box filter with tail zero-padding.
    mem1[0] = {8'd1, 8'd1, 8'd1, 8'd1};
    run("box", 2, 1'b0);
    check("box_w0", 64'(mem2[0]), 64'h16120E0A);
    check("box_w1", 64'(mem2[1]), 64'h080F151A);

    // Saturation.
    mem1[0] = 32'hFFFFFFFF;
    for (int j = 0; j < 16; j++) mem0[j] = 32'hFFFFFFFF;
    run("sat", 3, 1'b0);
    check("sat_w0", 64'(mem2[0]), 64'hFFFFFFFF);
    check("sat_w2", 64'(mem2[2]), 64'hFFFFFFFF);

    // Edge counts and clamping with random data.
    for (int j = 0; j < 16; j++) mem0[j] = $urandom;
    mem1[0] = {8'd3, 8'd0, 8'd7, 8'd2};
    run("zero", 0, 1'b0);
    run("full", 16, 1'b0);
    run("clamp", 20, 1'b0);
    mem1[0] = $urandom;
    run("poke", 6, 1'b1);

    // Asynchronous reset mid-run, then a fresh run.
    @(negedge clk);
    bus.Start     = 1'b1;
    bus.Num_Words = 5'd8;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_wen_before", 64'(bus.Out_En_Write), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_wen", 64'(bus.Out_En_Write), 64'd0);
    check("mid_wdata", 64'(bus.Out_Write_Data), 64'd0);
    check("mid_busy", 64'(bus.Busy), 64'd0);
    check("mid_ren", 64'(bus.In_En_Read), 64'd0);
    check("mid_cs", 64'(bus.Out_Chip_Select), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.Out_En_Write || bus.Done) cnt++;
    end
    check("mid_quiet", 64'(cnt), 64'd0);
    run("after_rst", 5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
